// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time program loader.
//   state_e     : loader FSM states (CHECK only reachable with LOADER_CHECKSUM_EN)
//   LEN_W       : width of the word-count header and word index counter
//   WORD_BYTES  : bytes per packed instruction word
//   CSUM_SEED   : initial value of the running XOR checksum
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE
  } state_e;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [7:0]  CSUM_SEED  = 8'h00;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from a byte stream.
//   clock, Reset  : clock and asynchronous active-high reset
//   clear         : discard any partially assembled word (priority over byte_valid)
//   byte_valid    : shift_in carries an accepted byte this cycle
//   shift_in      : incoming byte, most significant byte of the word first
//   word_ready    : this byte completes a word (combinational)
//   word          : completed word, valid when word_ready is high
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        Reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  shift_in,
  output logic        word_ready,
  output logic [31:0] word
);

  // Only the three earlier bytes need storage; the fourth is taken straight
  // from shift_in so the word is available in the cycle it completes.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_ready = byte_valid && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = {sr_q, shift_in};

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (byte_valid) begin
      sr_d  = {sr_q[15:0], shift_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that writes a streamed program image into
// instruction memory and holds the core in reset until the load is clean.
//   clock, Reset        : clock and asynchronous active-high reset
//   in_valid/in_data    : byte stream source; in_ready accepts a byte
//   reload              : single-cycle restart request, overrides everything
//   imem_we/addr/wdata  : registered instruction-memory write port
//   cpu_reset           : drives the core Reset; low only after an error-free load
//   load_done, load_err : load complete / overflow or checksum mismatch
// Stream: 16-bit word count N (high byte first), then 4*N bytes, MSB first.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic              pk_valid;
  logic              pk_ready;
  logic [31:0]       pk_word;

  assign in_ready = (state_q != DONE);
  // A byte presented alongside reload is dropped, not accepted.
  assign accept   = in_valid && in_ready && !reload;
  assign pk_valid = accept && (state_q == DATA);

  byte_packer u_packer (
    .clock      (clock),
    .Reset      (Reset),
    .clear      (reload),
    .byte_valid (pk_valid),
    .shift_in   (in_data),
    .word_ready (pk_ready),
    .word       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (reload) begin
      state_d = LEN_HI;
      len_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = CSUM_SEED;
`endif
    end else if (accept) begin
      unique case (state_q)
        LEN_HI: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = {len_q[15:8], in_data};
          if ({len_q[15:8], in_data} == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (pk_ready) begin
            // Words beyond memory depth are consumed but never written.
            if (32'(idx_q) < DEPTH) begin
              we_d    = 1'b1;
              addr_d  = ADDR_W'(idx_q);
              wdata_d = pk_word;
            end else begin
              err_d = 1'b1;
            end
            idx_d = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (in_data != csum_q) err_d = 1'b1;
`endif
          state_d = DONE;
          done_d  = 1'b1;
        end
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= CSUM_SEED;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign cpu_reset  = !(done_q && !err_q);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          Reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_err;

  prog_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  logic [31:0]   img[$];
  logic [31:0]   wr_data[$];
  logic [AW-1:0] wr_addr[$];
  int unsigned   wr_cyc[$];
  int unsigned   acc_cyc[$];
  int unsigned   done_cyc = 0;
  logic          done_prev = 1'b0;
  logic [7:0]    last_ck;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we) begin
      wr_data.push_back(imem_wdata);
      wr_addr.push_back(imem_addr);
      wr_cyc.push_back(cyc);
    end
    if (load_done && !done_prev) done_cyc = cyc;
    done_prev = load_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    if (in_ready && !reload) acc_cyc.push_back(cyc + 1);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    in_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clock);
    reload   = 1'b0;
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_addr.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cyc = 0;
  endtask

  task automatic stream(input bit toggle, input bit bad_ck);
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  ck;
    n  = 16'(img.size());
    ck = 8'h00;
    put(n[15:8]);
    put(n[7:0]);
    foreach (img[k]) begin
      w = img[k];
      for (int i = 3; i >= 0; i--) begin
        if (toggle) idle();
        put(w[i*8 +: 8]);
        ck ^= w[i*8 +: 8];
      end
    end
    if (bad_ck) ck = 8'hA5;
    last_ck = ck;
`ifdef LOADER_CHECKSUM_EN
    put(last_ck);
`endif
    repeat (4) idle();
  endtask

  task automatic check_writes(input string tag, input int nexp);
    chk({tag, "_wr_count"}, 32'(wr_data.size()), 32'(nexp));
    for (int k = 0; k < nexp && k < wr_data.size(); k++) begin
      chk($sformatf("%s_wr_data%0d", tag, k), wr_data[k], img[k]);
      chk($sformatf("%s_wr_addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
      chk($sformatf("%s_we_timing%0d", tag, k), wr_cyc[k], acc_cyc[4*k+5]);
    end
    chk({tag, "_done_timing"}, done_cyc, acc_cyc[acc_cyc.size()-1]);
  endtask

  initial begin
    Reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);
    @(negedge clock);
    Reset = 1'b0;

    // Two-word image, back to back
    clear_log();
    img = '{32'h24080005, 32'h8C090004};
    stream(1'b0, 1'b0);
    check_writes("s1", 2);
    if (wr_cyc.size() >= 2) chk("s1_we_gap", wr_cyc[1] - wr_cyc[0], 4);
    else chk("s1_we_gap_missing", 32'(wr_cyc.size()), 2);
    chk("s1_done", 32'(load_done), 1);
    chk("s1_err", 32'(load_err), 0);
    chk("s1_cpu_reset", 32'(cpu_reset), 0);
    chk("s1_done_in_ready", 32'(in_ready), 0);

    pulse_reload();
    chk("rl_done", 32'(load_done), 0);
    chk("rl_cpu_reset", 32'(cpu_reset), 1);
    chk("rl_in_ready", 32'(in_ready), 1);

    // Empty image
    clear_log();
    img.delete();
    stream(1'b0, 1'b0);
    check_writes("s2", 0);
    chk("s2_done", 32'(load_done), 1);
    chk("s2_err", 32'(load_err), 0);
    chk("s2_cpu_reset", 32'(cpu_reset), 0);

    // Same image with in_valid toggling
    pulse_reload();
    clear_log();
    img = '{32'h24080005, 32'h8C090004};
    stream(1'b1, 1'b0);
    check_writes("s3", 2);
    chk("s3_done", 32'(load_done), 1);
    chk("s3_cpu_reset", 32'(cpu_reset), 0);

    // Overflow: 5 words into a 4-word memory
    pulse_reload();
    clear_log();
    img = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
    stream(1'b0, 1'b0);
    check_writes("s4", 4);
    chk("s4_done", 32'(load_done), 1);
    chk("s4_err", 32'(load_err), 1);
    chk("s4_cpu_reset", 32'(cpu_reset), 1);

    // Reload after 6 bytes with a byte offered in the same cycle
    pulse_reload();
    clear_log();
    put(8'h00); put(8'h02); put(8'h24); put(8'h08); put(8'h00); put(8'h05);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h8C;
    reload   = 1'b1;
    @(negedge clock);
    reload   = 1'b0;
    in_valid = 1'b0;
    repeat (3) idle();
    chk("s5_partial_count", 32'(wr_data.size()), 1);
    if (wr_data.size() >= 1) chk("s5_partial_data", wr_data[0], 32'h24080005);
    chk("s5_partial_done", 32'(load_done), 0);
    chk("s5_partial_cpu_reset", 32'(cpu_reset), 1);
    clear_log();
    img = '{32'h11223344};
    stream(1'b0, 1'b0);
    check_writes("s5", 1);
    chk("s5_done", 32'(load_done), 1);
    chk("s5_cpu_reset", 32'(cpu_reset), 0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum
    pulse_reload();
    clear_log();
    img = '{32'h24080005, 32'h8C090004};
    stream(1'b0, 1'b1);
    check_writes("s6", 2);
    chk("s6_done", 32'(load_done), 1);
    chk("s6_err", 32'(load_err), 1);
    chk("s6_cpu_reset", 32'(cpu_reset), 1);
`endif

    // Asynchronous reset mid-load, then a clean reload
    pulse_reload();
    clear_log();
    put(8'h00); put(8'h01); put(8'hAA); put(8'hBB);
    @(negedge clock);
    in_valid = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("ar_wdata", imem_wdata, 0);
    chk("ar_addr", 32'(imem_addr), 0);
    chk("ar_we", 32'(imem_we), 0);
    chk("ar_cpu_reset", 32'(cpu_reset), 1);
    @(negedge clock);
    Reset = 1'b0;
    clear_log();
    img = '{32'h01020304};
    stream(1'b0, 1'b0);
    check_writes("s7", 1);
    chk("s7_done", 32'(load_done), 1);
    chk("s7_cpu_reset", 32'(cpu_reset), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
